// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the eight-digit seven-segment display with a minimum dwell per owner.
// Optional blink gating is compiled in with `define SEG_BLINK_EN.
module seg_display_arbiter #(
  parameter int NREQ       = 4,
  parameter int DWELL      = 1000,
  parameter int BLINK_HALF = 500000
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef SEG_BLINK_EN
  input  logic                 blink,
`endif
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   data,
  output logic [NREQ-1:0]      gnt,
  output logic [2:0]           owner,
  output logic [7:0]           o_seg0,
  output logic [7:0]           o_seg1,
  output logic [7:0]           o_seg2,
  output logic [7:0]           o_seg3,
  output logic [7:0]           o_seg4,
  output logic [7:0]           o_seg5,
  output logic [7:0]           o_seg6,
  output logic [7:0]           o_seg7
);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t      state_q, state_d;
  logic [2:0]  owner_q, owner_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [19:0] cnt_q, cnt_d;
  logic [31:0] val_q, val_d;

  logic [NREQ-1:0] own_oh;
  logic [NREQ-1:0] others;
  logic            own_req;
  logic            blank;
  logic [7:0][7:0] segs;

  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    logic [7:0] p;
    case (n)
      4'h0: p = 8'hFC;  4'h1: p = 8'h60;  4'h2: p = 8'hDA;  4'h3: p = 8'hF2;
      4'h4: p = 8'h66;  4'h5: p = 8'hB6;  4'h6: p = 8'hBE;  4'h7: p = 8'hE0;
      4'h8: p = 8'hFE;  4'h9: p = 8'hE6;  4'hA: p = 8'hEE;  4'hB: p = 8'h3E;
      4'hC: p = 8'h9C;  4'hD: p = 8'h7A;  4'hE: p = 8'h9E;  default: p = 8'h8E;
    endcase
    return p;
  endfunction

  // First set bit of r searching upward from p, wrapping modulo NREQ.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r, input logic [2:0] p);
    logic [2:0] pick;
    logic       found;
    pick  = 3'd0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (int'(p) + i) % NREQ;
      if (!found && r[idx]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [2:0] next_idx(input logic [2:0] s);
    return 3'((int'(s) + 1) % NREQ);
  endfunction

  function automatic logic [31:0] data_of(input logic [2:0] s);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == s) v = data[32*i +: 32];
    end
    return v;
  endfunction

  assign own_oh  = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
  assign others  = req & ~own_oh;
  assign own_req = |(req & own_oh);

  always_comb begin
    logic [2:0] s;
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    s       = 3'd0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          s       = rr_pick(req, ptr_q);
          state_d = SHOW;
          owner_d = s;
          val_d   = data_of(s);
          cnt_d   = 20'(DWELL - 1);
          ptr_d   = next_idx(s);
        end
      end
      default: begin
        if ((!own_req || cnt_q == 20'd0) && |others) begin
          // Release hands over regardless of dwell; an expired dwell yields to any waiter.
          s       = rr_pick(others, ptr_q);
          owner_d = s;
          val_d   = data_of(s);
          cnt_d   = 20'(DWELL - 1);
          ptr_d   = next_idx(s);
        end else if (!own_req) begin
          state_d = IDLE;
          owner_d = 3'd0;
        end else begin
          val_d = data_of(owner_q);
          cnt_d = (cnt_q == 20'd0) ? 20'd0 : cnt_q - 20'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 3'd0;
      ptr_q   <= 3'd0;
      cnt_q   <= 20'd0;
      val_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
    end
  end

`ifdef SEG_BLINK_EN
  logic [31:0] bcnt_q;
  logic        phase_off_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q      <= 32'd0;
      phase_off_q <= 1'b0;
    end else if (bcnt_q == 32'(BLINK_HALF - 1)) begin
      bcnt_q      <= 32'd0;
      phase_off_q <= ~phase_off_q;
    end else begin
      bcnt_q <= bcnt_q + 32'd1;
    end
  end

  assign blank = (state_q != SHOW) || (blink && phase_off_q);
`else
  assign blank = (state_q != SHOW);
`endif

  assign gnt   = (state_q == SHOW) ? own_oh : '0;
  assign owner = owner_q;

  always_comb begin
    segs = '1;
    for (int k = 0; k < 8; k++) begin
      if (!blank) segs[k] = ~seg_decode(val_q[4*k +: 4]);
    end
  end

  assign o_seg0 = segs[0];
  assign o_seg1 = segs[1];
  assign o_seg2 = segs[2];
  assign o_seg3 = segs[3];
  assign o_seg4 = segs[4];
  assign o_seg5 = segs[5];
  assign o_seg6 = segs[6];
  assign o_seg7 = segs[7];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter (NREQ=4, DWELL=4): driver queues expectations, monitor compares.
module tb_seg_display_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] data;
  logic [3:0]   gnt;
  logic [2:0]   owner;
  logic [7:0]   o_seg0, o_seg1, o_seg2, o_seg3, o_seg4, o_seg5, o_seg6, o_seg7;
`ifdef SEG_BLINK_EN
  logic         blink = 1'b0;
`endif

  seg_display_arbiter #(.NREQ(4), .DWELL(4), .BLINK_HALF(3)) dut (
    .clk(clk), .rst(rst),
`ifdef SEG_BLINK_EN
    .blink(blink),
`endif
    .req(req), .data(data), .gnt(gnt), .owner(owner),
    .o_seg0(o_seg0), .o_seg1(o_seg1), .o_seg2(o_seg2), .o_seg3(o_seg3),
    .o_seg4(o_seg4), .o_seg5(o_seg5), .o_seg6(o_seg6), .o_seg7(o_seg7)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  g;
    logic [2:0]  o;
    logic [63:0] s;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] d [4];
  event        mid_ev;

  localparam logic [63:0] BLANK = 64'hFFFF_FFFF_FFFF_FFFF;
  logic [7:0] tbl [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                           8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  function automatic logic [63:0] exp_segs(input logic [31:0] v);
    logic [63:0] s;
    for (int k = 0; k < 8; k++) s[8*k +: 8] = ~tbl[v[4*k +: 4]];
    return s;
  endfunction

  task automatic push(input logic [3:0] g, input logic [2:0] o, input logic [63:0] s, input string nm);
    exp_t e;
    e.g = g; e.o = o; e.s = s; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [2:0] eo,
                      input logic show, input int di, input string nm);
    @(negedge clk);
    req  = r;
    data = {d[3], d[2], d[1], d[0]};
    @(posedge clk);
    #1 push(eg, eo, show ? exp_segs(d[di]) : BLANK, nm);
  endtask

  initial begin
    forever begin
      @(negedge clk or mid_ev);
      while (sb.size() > 0) begin
        exp_t e;
        logic [63:0] act;
        e   = sb.pop_front();
        act = {o_seg7, o_seg6, o_seg5, o_seg4, o_seg3, o_seg2, o_seg1, o_seg0};
        checks++;
        if (gnt !== e.g || owner !== e.o || act !== e.s) begin
          errors++;
          $display("FAIL %s: got gnt=%b owner=%0d seg=%h, expected gnt=%b owner=%0d seg=%h",
                   e.nm, gnt, owner, act, e.g, e.o, e.s);
        end
      end
    end
  end

  initial begin
    int own;
    d[0] = 32'h7654_3210; d[1] = 32'hFEDC_BA98; d[2] = 32'h0A1B_2C3D; d[3] = 32'h1357_9BDF;
    rst  = 1'b0;
    req  = 4'b0000;
    data = {d[3], d[2], d[1], d[0]};
    repeat (2) @(posedge clk);
    #1 push(4'b0000, 3'd0, BLANK, "reset");
    @(negedge clk);
    rst = 1'b1;

    step(4'b0001, 4'b0001, 3'd0, 1'b1, 0, "first_grant");
    d[0] = 32'h89AB_CDEF;
    step(4'b0001, 4'b0001, 3'd0, 1'b1, 0, "data_follow");
    step(4'b0001, 4'b0001, 3'd0, 1'b1, 0, "hold_cnt1");
    step(4'b0001, 4'b0001, 3'd0, 1'b1, 0, "hold_cnt0");
    step(4'b0001, 4'b0001, 3'd0, 1'b1, 0, "hold_alone");

    for (int k = 0; k < 17; k++) begin
      own = (1 + k / 4) % 4;
      step(4'b1111, 4'b0001 << own, 3'(own), 1'b1, own, $sformatf("rr%0d", k));
    end

    step(4'b0110, 4'b0010, 3'd1, 1'b1, 1, "no_preempt");
    step(4'b0100, 4'b0100, 3'd2, 1'b1, 2, "early_release");
    step(4'b0000, 4'b0000, 3'd0, 1'b0, 0, "idle_blank");
    step(4'b1001, 4'b1000, 3'd3, 1'b1, 3, "resume_from_ptr");
    step(4'b1010, 4'b1000, 3'd3, 1'b1, 3, "hold_owner3");
    step(4'b0010, 4'b0010, 3'd1, 1'b1, 1, "switch_to_1");

    @(negedge clk);
    #1 rst = 1'b0;
    req = 4'b0000;
    #1 push(4'b0000, 3'd0, BLANK, "async_reset");
    -> mid_ev;
    @(negedge clk);
    rst = 1'b1;

    step(4'b0000, 4'b0000, 3'd0, 1'b0, 0, "idle_after_reset");
    step(4'b0011, 4'b0001, 3'd0, 1'b1, 0, "grant_after_reset");
    step(4'b0011, 4'b0001, 3'd0, 1'b1, 0, "hold_after_reset");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
